implication_monitor: RTL and testbench
======================================

Name: implication_monitor

Overview:
- Synthesizable runtime checker for the temporal implication "antecedent |-> ##DELAY consequent".
- Hardware counterpart of the simulation-only concurrent assertions embedded in our generated modules.
- Sits alongside a DUT, for example on an FF's input and output.
- Tracks outstanding obligations cycle by cycle and flags, counts and optionally timestamps each violation.
- Intended for FPGA and emulation builds where SVA is unavailable.

Parameters:
- DELAY, 1: cycles between antecedent sample and consequent check. Must be >= 1; DELAY=0 is an elaboration error.
- CNT_W, 8: width of the violation counter.
- TS_W, 16: width of the cycle timestamp (used only with the optional feature).

Ports:
- CLK  input  1  sole clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- enable  input  1  when high, a high antecedent creates a new obligation.
- clear  input  1  synchronous soft clear of obligations, counter and sticky flags.
- antecedent  input  1  trigger signal (the "I" side).
- consequent  input  1  checked signal (the "O" side).
- violation  output  1  registered one-cycle pulse per failed obligation.
- violation_count  output  CNT_W  saturating count of violations.
- overflow  output  1  sticky; set on any violation while the count is saturated.
- pending  output  1  high while any obligation is in flight.
- first_fail_valid  output  1  sticky; set on the first violation since reset or clear.
- first_fail_cycle  output  TS_W  cycle index of the first violation.

Behaviour:
- Obligation pipe is a DELAY-bit shift register obl[DELAY-1:0].
  - Each cycle: obl[0] <= enable & antecedent; obl[i] <= obl[i-1].
- Check: in cycle t+DELAY, if obl[DELAY-1]=1 and consequent=0, then violation=1 in cycle t+DELAY+1.
  - Otherwise violation=0 in that cycle.
  - Latency from the antecedent sample to the violation pulse is DELAY+1 cycles.
- Each obligation is checked independently, so overlapping triggers on consecutive cycles each produce their own check.
- A maturing obligation and a new antecedent in the same cycle are both handled normally.
- Deasserting enable blocks only new obligations; obligations already in flight still mature and are checked.
- Counter: violation_count increments by 1 in the same cycle violation is registered high.
  - It saturates at 2^CNT_W-1 with no wrap.
  - A further violation while saturated sets overflow, which stays set until RESET or clear.
- pending = |obl (combinational from registered state).
- Priority order: RESET > clear > normal operation.
  - RESET or clear empties the obligation pipe and zeroes the counter, overflow, first_fail_valid, first_fail_cycle and violation.
  - Consequent is not checked in a cycle where RESET or clear is asserted.
  - Antecedent is not captured in a cycle where RESET or clear is asserted.
  - The cycle counter resets on RESET only.
- Reset values: every output is 0.
- Asserting RESET mid-operation discards all in-flight obligations, and no violation is ever reported for them.

Optional Feature:
- Macro IMPL_MON_TIMESTAMP_EN.
- With the macro defined:
  - A free-running TS_W-bit cycle counter runs, wrapping modulo 2^TS_W.
  - On the first violation after RESET or clear, its value in the check cycle is latched into first_fail_cycle and first_fail_valid is set.
  - Later violations leave both unchanged.
- Without the macro:
  - The ports still exist, tied to 0.
  - No cycle counter is instantiated.

Decomposition:
- Shared package impl_mon_pkg holds:
  - typedef viol_cnt_t (logic [CNT_W-1:0] default),
  - typedef cycle_ts_t,
  - localparam VIOL_CNT_MAX,
  - a function sat_inc(count) that returns the saturated increment.
- One sub-module is natural: impl_mon_obligation_pipe (parameterized DELAY shift register with synchronous flush, exposing the matured bit and the pending OR).
- The top level holds the check, counter, sticky flags and timestamp logic.

Test Plan:
- Basic pass and fail (DELAY=1, enable=1):
  - antecedent=1 at cycle 5 with consequent=1 at cycle 6 gives no violation.
  - antecedent=1 at cycle 10 with consequent=0 at cycle 11 gives violation=1 at cycle 12 only, and violation_count=1.
- Overlap (DELAY=3): antecedent high for cycles 0-2 with consequent=0 throughout gives violation pulses at cycles 4, 5, 6, violation_count=3 and pending low from cycle 6.
- Enable gating: antecedent at cycle 0 with enable=1, enable dropped at cycle 1, antecedent at cycle 2, consequent=0 (DELAY=1) gives exactly one violation, at cycle 2.
- Saturation (CNT_W=2): force 5 violations; violation_count stops at 3 and overflow is set on the 4th violation and stays set.
- Reset and clear mid-flight (DELAY=4):
  - antecedent at cycle 0 then RESET at cycle 2 gives no violation, and all outputs are 0 at cycle 3.
  - Repeating with clear gives the same result.
- Timestamp (IMPL_MON_TIMESTAMP_EN, DELAY=1):
  - First failing check at cycle-counter value 37 gives first_fail_valid=1 and first_fail_cycle=37.
  - A later violation leaves 37 unchanged.
  - With the macro undefined, both ports stay 0.

Source files
------------

// File: rtl/impl_mon_pkg.sv
// impl_mon_pkg
// Shared types and helpers for the implication monitor.
//   viol_cnt_t / cycle_ts_t : default-width violation count and cycle stamp
//   VIOL_CNT_MAX            : saturation value at the default count width
//   sat_inc()               : saturating +1, width-agnostic so that monitors
//                             built with a non-default CNT_W can share it
package impl_mon_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TS_W_DEF  = 16;

  typedef logic [CNT_W_DEF-1:0] viol_cnt_t;
  typedef logic [TS_W_DEF-1:0]  cycle_ts_t;

  localparam viol_cnt_t VIOL_CNT_MAX = '1;

  // Values are carried in 32 bits; the caller passes its own ceiling and
  // truncates the result back to its counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic [31:0] max_val = 32'(VIOL_CNT_MAX));
    return (count >= max_val) ? max_val : count + 32'd1;
  endfunction

endpackage

// File: rtl/implication_monitor_if.sv
// implication_monitor_if
// Bundles the monitored/control inputs and the status outputs of one
// implication monitor.
//   master : environment side, drives enable/clear/antecedent/consequent
//   slave  : monitor side, drives violation and status
// Parameters CNT_W / TS_W must match the attached monitor.
interface implication_monitor_if #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
);
  import impl_mon_pkg::*;

  logic             enable;
  logic             clear;
  logic             antecedent;
  logic             consequent;
  logic             violation;
  logic [CNT_W-1:0] violation_count;
  logic             overflow;
  logic             pending;
  logic             first_fail_valid;
  logic [TS_W-1:0]  first_fail_cycle;

  modport master (
    output enable, clear, antecedent, consequent,
    input  violation, violation_count, overflow, pending,
           first_fail_valid, first_fail_cycle
  );

  modport slave (
    input  enable, clear, antecedent, consequent,
    output violation, violation_count, overflow, pending,
           first_fail_valid, first_fail_cycle
  );

endinterface

// File: rtl/impl_mon_obligation_pipe.sv
// impl_mon_obligation_pipe
// DELAY-deep shift register of outstanding obligations.
//   clk_i     : clock
//   flush_i   : synchronous flush, dominates push_i (also used as reset)
//   push_i    : new obligation entering stage 0
//   matured_o : obligation that is due for checking this cycle
//   pending_o : any obligation in flight
module impl_mon_obligation_pipe #(
  parameter int DELAY = 1
) (
  input  logic clk_i,
  input  logic flush_i,
  input  logic push_i,
  output logic matured_o,
  output logic pending_o
);
  import impl_mon_pkg::*;

  logic [DELAY-1:0] obl_q, obl_d;

  always_comb begin
    obl_d = '0;
    if (!flush_i) begin
      obl_d[0] = push_i;
      for (int i = 1; i < DELAY; i++) begin
        obl_d[i] = obl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    obl_q <= obl_d;
  end

  assign matured_o = obl_q[DELAY-1];
  assign pending_o = |obl_q;

endmodule

// File: rtl/implication_monitor.sv
// implication_monitor
// Runtime checker for "antecedent |-> ##DELAY consequent".
// Each enabled antecedent creates an obligation; DELAY cycles later the
// consequent must be high, otherwise a one-cycle violation pulse follows.
//   CLK, RESET : clock, synchronous active-high reset
//   mon        : implication_monitor_if.slave
//                in : enable, clear, antecedent, consequent
//                out: violation, violation_count, overflow, pending,
//                     first_fail_valid, first_fail_cycle
// Optional: define IMPL_MON_TIMESTAMP_EN to add a free-running cycle
// counter and capture the check-cycle stamp of the first violation.
// Without it first_fail_valid/first_fail_cycle read as 0.
module implication_monitor
  import impl_mon_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input logic                  CLK,
  input logic                  RESET,
  implication_monitor_if.slave mon
);

  if (DELAY < 1) begin : g_bad_delay
    $error("implication_monitor: DELAY must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("implication_monitor: CNT_W must be in 1..32");
  end
  if (TS_W < 1) begin : g_bad_ts_w
    $error("implication_monitor: TS_W must be >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             flush;
  logic             matured;
  logic             check_fail;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // RESET and clear both empty the pipe and suppress capture and check.
  assign flush = RESET | mon.clear;

  impl_mon_obligation_pipe #(
    .DELAY (DELAY)
  ) u_pipe (
    .clk_i     (CLK),
    .flush_i   (flush),
    .push_i    (mon.enable & mon.antecedent),
    .matured_o (matured),
    .pending_o (mon.pending)
  );

  assign check_fail = matured & ~mon.consequent;

  always_comb begin
    viol_d = 1'b0;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (flush) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (check_fail) begin
      viol_d = 1'b1;
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      viol_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      viol_q <= viol_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign mon.violation       = viol_q;
  assign mon.violation_count = cnt_q;
  assign mon.overflow        = ovf_q;

`ifdef IMPL_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic            ffv_q, ffv_d;
  logic [TS_W-1:0] ffc_q, ffc_d;

  always_comb begin
    ffv_d = ffv_q;
    ffc_d = ffc_q;
    if (flush) begin
      ffv_d = 1'b0;
      ffc_d = '0;
    end else if (check_fail && !ffv_q) begin
      ffv_d = 1'b1;
      ffc_d = ts_q;
    end
  end

  // Cycle counter restarts on RESET only; clear leaves it running.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_q  <= '0;
      ffv_q <= 1'b0;
      ffc_q <= '0;
    end else begin
      ts_q  <= ts_q + TS_W'(1);
      ffv_q <= ffv_d;
      ffc_q <= ffc_d;
    end
  end

  assign mon.first_fail_valid = ffv_q;
  assign mon.first_fail_cycle = ffc_q;
`else
  assign mon.first_fail_valid = 1'b0;
  assign mon.first_fail_cycle = '0;
`endif

endmodule

// File: tb/tb_implication_monitor.sv
// tb_implication_monitor
// Three monitors (DELAY=1/CNT_W=2, DELAY=3, DELAY=4) share one stimulus
// stream. A cycle-indexed model derives every output from the history of
// captured antecedents, and literal expectations pin key scenarios.
module tb_implication_monitor;

`ifdef IMPL_MON_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET, en, clr, ant, cons;

  always #5 CLK = ~CLK;

  implication_monitor_if #(.CNT_W(2), .TS_W(16)) if_a ();
  implication_monitor_if #(.CNT_W(8), .TS_W(16)) if_b ();
  implication_monitor_if #(.CNT_W(8), .TS_W(16)) if_c ();

  assign if_a.enable = en;  assign if_a.clear = clr;
  assign if_a.antecedent = ant;  assign if_a.consequent = cons;
  assign if_b.enable = en;  assign if_b.clear = clr;
  assign if_b.antecedent = ant;  assign if_b.consequent = cons;
  assign if_c.enable = en;  assign if_c.clear = clr;
  assign if_c.antecedent = ant;  assign if_c.consequent = cons;

  implication_monitor #(.DELAY(1), .CNT_W(2), .TS_W(16)) u_a (.CLK(CLK), .RESET(RESET), .mon(if_a));
  implication_monitor #(.DELAY(3), .CNT_W(8), .TS_W(16)) u_b (.CLK(CLK), .RESET(RESET), .mon(if_b));
  implication_monitor #(.DELAY(4), .CNT_W(8), .TS_W(16)) u_c (.CLK(CLK), .RESET(RESET), .mon(if_c));

  logic [31:0] act_viol[3], act_cnt[3], act_ovf[3], act_pend[3], act_ffv[3], act_ffc[3];

  assign act_viol[0] = 32'(if_a.violation);
  assign act_viol[1] = 32'(if_b.violation);
  assign act_viol[2] = 32'(if_c.violation);
  assign act_cnt[0]  = 32'(if_a.violation_count);
  assign act_cnt[1]  = 32'(if_b.violation_count);
  assign act_cnt[2]  = 32'(if_c.violation_count);
  assign act_ovf[0]  = 32'(if_a.overflow);
  assign act_ovf[1]  = 32'(if_b.overflow);
  assign act_ovf[2]  = 32'(if_c.overflow);
  assign act_pend[0] = 32'(if_a.pending);
  assign act_pend[1] = 32'(if_b.pending);
  assign act_pend[2] = 32'(if_c.pending);
  assign act_ffv[0]  = 32'(if_a.first_fail_valid);
  assign act_ffv[1]  = 32'(if_b.first_fail_valid);
  assign act_ffv[2]  = 32'(if_c.first_fail_valid);
  assign act_ffc[0]  = 32'(if_a.first_fail_cycle);
  assign act_ffc[1]  = 32'(if_b.first_fail_cycle);
  assign act_ffc[2]  = 32'(if_c.first_fail_cycle);

  // ---------------- model ----------------
  int D[3]    = '{1, 3, 4};
  int CMAX[3] = '{3, 255, 255};
  bit cap[0:4095];
  int cyc = 0;
  int last_flush = -1;
  int last_rst = -1;
  int e_viol[3], e_cnt[3], e_ovf[3], e_pend[3], e_ffv[3], e_ffc[3];
  int checks = 0;
  int errors = 0;

  // Called right after a rising edge: the inputs still hold the values
  // sampled at that edge; updates expectations for the following cycle.
  task automatic model_step();
    bit fl;
    bit fail;
    int s;
    fl = RESET || clr;
    cap[cyc] = !fl && en && ant;
    if (RESET) last_rst = cyc;
    if (fl) last_flush = cyc;
    for (int i = 0; i < 3; i++) begin
      if (fl) begin
        e_viol[i] = 0; e_cnt[i] = 0; e_ovf[i] = 0; e_ffv[i] = 0; e_ffc[i] = 0;
      end else begin
        s = cyc - D[i];
        fail = 1'b0;
        if (s >= 0 && s > last_flush) begin
          if (cap[s] && !cons) fail = 1'b1;
        end
        e_viol[i] = fail ? 1 : 0;
        if (fail) begin
          if (e_cnt[i] == CMAX[i]) e_ovf[i] = 1;
          else e_cnt[i] = e_cnt[i] + 1;
          if (TS_ON && e_ffv[i] == 0) begin
            e_ffv[i] = 1;
            e_ffc[i] = (cyc - last_rst - 1) % 65536;
          end
        end
      end
      e_pend[i] = 0;
      for (int k = cyc - D[i] + 1; k <= cyc; k++) begin
        if (k >= 0 && k > last_flush) begin
          if (cap[k]) e_pend[i] = 1;
        end
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s[%0d] cycle %0d got %0d want %0d", nm, idx, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("violation", i, act_viol[i], e_viol[i]);
      chk("violation_count", i, act_cnt[i], e_cnt[i]);
      chk("overflow", i, act_ovf[i], e_ovf[i]);
      chk("pending", i, act_pend[i], e_pend[i]);
      chk("first_fail_valid", i, act_ffv[i], e_ffv[i]);
      chk("first_fail_cycle", i, act_ffc[i], e_ffc[i]);
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit c, input bit a, input bit q);
    RESET = r; en = e; clr = c; ant = a; cons = q;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_viol", 0, act_viol[0], 0);
    chk("rst_cnt", 0, act_cnt[0], 0);
    chk("rst_ovf", 0, act_ovf[0], 0);
    chk("rst_pend", 0, act_pend[0], 0);
    chk("rst_ffv", 0, act_ffv[0], 0);
    chk("rst_ffc", 0, act_ffc[0], 0);
    idle(2);

    // basic pass then fail on DELAY=1
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("basic_pend", 0, act_pend[0], 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("basic_pass_viol", 0, act_viol[0], 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("basic_fail_viol", 0, act_viol[0], 1);
    chk("basic_fail_cnt", 0, act_cnt[0], 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("basic_pulse_end", 0, act_viol[0], 0);
    chk("basic_cnt_hold", 0, act_cnt[0], 1);

    // overlap on DELAY=3
    idle(5);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_cnt", 1, act_cnt[1], 0);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovl_viol_c4", 1, act_viol[1], 1);
    chk("ovl_cnt_c4", 1, act_cnt[1], 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovl_viol_c5", 1, act_viol[1], 1);
    chk("ovl_pend_c5", 1, act_pend[1], 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovl_viol_c6", 1, act_viol[1], 1);
    chk("ovl_cnt_c6", 1, act_cnt[1], 3);
    chk("ovl_pend_c6", 1, act_pend[1], 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovl_viol_c7", 1, act_viol[1], 0);

    // enable gating on DELAY=1
    idle(5);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gate_viol_c2", 0, act_viol[0], 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gate_viol_c3", 0, act_viol[0], 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gate_viol_c4", 0, act_viol[0], 0);
    chk("gate_cnt", 0, act_cnt[0], 1);

    // saturation on CNT_W=2
    idle(3);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt_3rd", 0, act_cnt[0], 3);
    chk("sat_ovf_3rd", 0, act_ovf[0], 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt_4th", 0, act_cnt[0], 3);
    chk("sat_ovf_4th", 0, act_ovf[0], 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_viol_5th", 0, act_viol[0], 1);
    idle(2);
    chk("sat_ovf_sticky", 0, act_ovf[0], 1);
    chk("sat_cnt_final", 0, act_cnt[0], 3);

    // RESET mid-flight on DELAY=4
    idle(5);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstmid_viol", 2, act_viol[2], 0);
    chk("rstmid_cnt", 2, act_cnt[2], 0);
    chk("rstmid_ovf", 2, act_ovf[2], 0);
    chk("rstmid_pend", 2, act_pend[2], 0);
    chk("rstmid_ffv", 2, act_ffv[2], 0);
    for (int j = 0; j < 6; j++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rstmid_no_viol", 2, act_viol[2], 0);
    end

    // clear mid-flight on DELAY=4
    idle(5);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clrmid_pend", 2, act_pend[2], 0);
    chk("clrmid_cnt", 2, act_cnt[2], 0);
    for (int j = 0; j < 6; j++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("clrmid_no_viol", 2, act_viol[2], 0);
    end

    // timestamp: first failing check at counter value 37
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(36);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ts_viol", 0, act_viol[0], 1);
    chk("ts_ffv", 0, act_ffv[0], TS_ON ? 1 : 0);
    chk("ts_ffc", 0, act_ffc[0], TS_ON ? 37 : 0);
    idle(4);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ts_viol_2nd", 0, act_viol[0], 1);
    chk("ts_ffc_hold", 0, act_ffc[0], TS_ON ? 37 : 0);
    chk("ts_ffv_hold", 0, act_ffv[0], TS_ON ? 1 : 0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
